crc_frame_tx: RTL



---
 rtl/crc_pkg.sv | 20 ++
 rtl/crc_frame_tx_if.sv | 27 ++
 rtl/crc_p1001_calc.sv | 11 +
 rtl/crc_frame_tx.sv | 121 ++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the x^3+1 (poly 1001) 7-bit CRC link: widths, FSM state type
// and the reference CRC function used by both transmit and receive sides.
package crc_pkg;

  localparam int unsigned DATA_W = 7;
  localparam int unsigned CRC_W  = 3;
  localparam int unsigned CW_W   = 10;
  localparam logic [3:0]  POLY   = 4'b1001;

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  function automatic logic [CRC_W-1:0] crc_calc(input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] crc;
    crc[0] = data[0] ^ data[3] ^ data[6];
    crc[1] = data[1] ^ data[4];
    crc[2] = data[2] ^ data[5];
    return crc;
  endfunction

endpackage

// File: rtl/crc_frame_tx_if.sv
// Word-in / bit-out link bundle for crc_frame_tx: valid/ready word input and the
// serial codeword output with start/end-of-frame markers.
interface crc_frame_tx_if;
  import crc_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ser_valid;
  logic              ser_data;
  logic              ser_sof;
  logic              ser_eof;
  logic              ser_ready;

  // Environment side: supplies words and consumes serial bits.
  modport master (
    output in_valid, in_data, ser_ready,
    input  in_ready, ser_valid, ser_data, ser_sof, ser_eof
  );

  // Transmitter side.
  modport slave (
    input  in_valid, in_data, ser_ready,
    output in_ready, ser_valid, ser_data, ser_sof, ser_eof
  );

endinterface

// File: rtl/crc_p1001_calc.sv
// Combinational 7-to-3 CRC for polynomial x^3+1.
module crc_p1001_calc
  import crc_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc
);

  assign crc = crc_calc(data);

endmodule

// File: rtl/crc_frame_tx.sv
// Serializes {crc, data} codewords LSB-first with backpressure and optional inter-frame gap.
// Define CRC_ERR_INJECT_EN to add the err_inject port that corrupts crc[0] on acceptance.
module crc_frame_tx
  import crc_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef CRC_ERR_INJECT_EN
  input  logic                 err_inject,
`endif
  crc_frame_tx_if.slave        bus,
  output logic [CNT_W-1:0]     frames_sent
);

  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [CRC_W-1:0] crc;
  logic             inj;
  logic [CW_W-1:0]  cw;

  state_e           state_q;
  logic [CW_W-1:0]  shreg_q;
  logic [3:0]       idx_q;
  logic [GapW-1:0]  gap_cnt_q;
  logic [CNT_W-1:0] frames_q;
  logic             in_ready_q;
  logic             ser_valid_q;
  logic             ser_data_q;
  logic             ser_sof_q;
  logic             ser_eof_q;

  crc_p1001_calc u_crc (
    .data (bus.in_data),
    .crc  (crc)
  );

`ifdef CRC_ERR_INJECT_EN
  assign inj = err_inject;
`else
  assign inj = 1'b0;
`endif

  assign cw = {crc[2:1], crc[0] ^ inj, bus.in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      idx_q       <= '0;
      gap_cnt_q   <= '0;
      frames_q    <= '0;
      in_ready_q  <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_sof_q   <= 1'b0;
      ser_eof_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            shreg_q     <= cw;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            ser_valid_q <= 1'b1;
            ser_data_q  <= cw[0];
            ser_sof_q   <= 1'b1;
            ser_eof_q   <= 1'b0;
            state_q     <= StSend;
          end
        end
        StSend: begin
          // Outputs only move on a handshake so a stalled bit stays put.
          if (bus.ser_ready) begin
            shreg_q <= shreg_q >> 1;
            if (idx_q == 4'd9) begin
              frames_q    <= frames_q + CNT_W'(1);
              ser_valid_q <= 1'b0;
              ser_data_q  <= 1'b0;
              ser_sof_q   <= 1'b0;
              ser_eof_q   <= 1'b0;
              gap_cnt_q   <= '0;
              if (GAP_CYCLES > 0) begin
                state_q <= StGap;
              end else begin
                in_ready_q <= 1'b1;
                state_q    <= StIdle;
              end
            end else begin
              idx_q      <= idx_q + 4'd1;
              ser_data_q <= shreg_q[1];
              ser_sof_q  <= 1'b0;
              ser_eof_q  <= (idx_q == 4'd8);
            end
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            in_ready_q <= 1'b1;
            state_q    <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + GapW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_data  = ser_data_q;
  assign bus.ser_sof   = ser_sof_q;
  assign bus.ser_eof   = ser_eof_q;
  assign frames_sent   = frames_q;

endmodule
